// File: rtl/flappy_pkg.sv
// Shared constants for the flappy game-state controller: scene codes, the
// input byte for space, pipe field layout, the constant gap-centre table and
// configuration sanity helpers.
// Optional feature macro used elsewhere: FLAPPY_LFSR_GAP_EN.
package flappy_pkg;

  typedef enum logic [1:0] {
    SC_SPLASH   = 2'd0,
    SC_PLAYING  = 2'd1,
    SC_GAMEOVER = 2'd2
  } scene_e;

  localparam logic [7:0] SPACE = 8'd32;

  // Each pipe occupies PIPE_W bits of the pipes bus: {position, max_bnd, min_bnd}
  localparam int PIPE_W  = 24;
  localparam int POS_OFF = 16;
  localparam int MAX_OFF = 8;
  localparam int MIN_OFF = 0;

  // Positions are 8-bit unsigned, so the whole pipe train must fit in a byte
  localparam int POS_LIMIT = 255;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // Gap centres used when the LFSR source is not built in
  function automatic logic [7:0] centre_tbl(input logic [1:0] idx);
    logic [7:0] c;
    case (idx)
      2'd0:    c = 8'd25;
      2'd1:    c = 8'd20;
      2'd2:    c = 8'd30;
      default: c = 8'd15;
    endcase
    return c;
  endfunction

  // Static check of the pipe layout and counters against the 8-bit datapath
  function automatic bit cfg_ok(input int n_pipe, input int spacing,
                                input int holdoff, input int kp_buflen);
    return (n_pipe > 0) && (spacing > 0) && (n_pipe * spacing <= POS_LIMIT) &&
           (holdoff >= 0) && (holdoff <= 255) && (kp_buflen >= 2);
  endfunction

endpackage

// File: rtl/flappy_gap_gen.sv
// Gap-centre source for respawning pipes.
// FLAPPY_LFSR_GAP_EN defined: 8-bit Fibonacci LFSR (taps 8,6,5,4), free running,
// centre = GAP/2 + 2 + lfsr[4:0].
// Undefined: steps through the constant centre table once per respawn strobe.
module flappy_gap_gen
  import flappy_pkg::*;
#(
  parameter int GAP = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       next,
  output logic [7:0] centre
);

`ifdef FLAPPY_LFSR_GAP_EN
  logic [7:0] lfsr;
  logic       unused_next;

  // The LFSR advances every cycle regardless of scene; respawns just sample it
  assign unused_next = next;

  // Shift left, feedback from bits 8,6,5,4 (1-based)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign centre = 8'(GAP / 2 + 2) + {3'b000, lfsr[4:0]};
`else
  logic [1:0] rsp_cnt;

  // One table step per respawn event, wrapping every four respawns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    rsp_cnt <= 2'd0;
    else if (next) rsp_cnt <= rsp_cnt + 2'd1;
  end

  assign centre = centre_tbl(rsp_cnt);
`endif

endmodule

// File: rtl/flappy_ctrl_gen.sv
// Game-state controller: fixed-point bird physics, N pipe pairs with respawn,
// collision detection, scoring and restart from game-over.
// Optional feature macro: FLAPPY_LFSR_GAP_EN (selects the LFSR gap source
// inside flappy_gap_gen; default build uses the constant centre table).
module flappy_ctrl_gen
  import flappy_pkg::*;
#(
  parameter int N_PIPE       = 3,
  parameter int FRAC_W       = 8,
  parameter int FLAP_V       = 77,
  parameter int GRAVITY      = 3,
  parameter int VMIN         = -256,
  parameter int START_ALT    = 20,
  parameter int KP_BUFLEN    = 5,
  parameter int PIPE_SPACING = 50,
  parameter int GAP          = 10,
  parameter int BIRD_COL     = 4,
  parameter int HOLDOFF      = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            inp,
  input  logic [7:0]            n_row,
  input  logic [7:0]            n_col,
  output logic [1:0]            scene,
  output logic [8:0]            bird,
  output logic [24*N_PIPE-1:0]  pipes,
  output logic [15:0]           score
);

  localparam int YW = 8 + FRAC_W + 1;

  localparam logic signed [YW-1:0] FLAP_S  = YW'(FLAP_V);
  localparam logic signed [YW-1:0] GRAV_S  = YW'(GRAVITY);
  localparam logic signed [YW-1:0] VMIN_S  = YW'(VMIN);
  localparam logic signed [YW-1:0] Y_INIT  = YW'(START_ALT << FRAC_W);
  localparam logic [7:0]           HALF_GAP    = 8'(GAP / 2);
  localparam logic [7:0]           RESPAWN_POS = 8'(N_PIPE * PIPE_SPACING - 1);
  localparam logic [7:0]           HOLD_MAX    = 8'(HOLDOFF);

  if (!cfg_ok(N_PIPE, PIPE_SPACING, HOLDOFF, KP_BUFLEN)) begin : g_bad_cfg
    $error("flappy_ctrl_gen: pipe train exceeds 8-bit position range or bad counter sizing");
  end

  // Reset/restart layout: pipe i at (i+1)*spacing, centred on table entry i mod 4
  function automatic logic [N_PIPE-1:0][7:0] init_field(input int sel);
    logic [N_PIPE-1:0][7:0] f;
    logic [7:0]             c;
    for (int i = 0; i < N_PIPE; i++) begin
      c = centre_tbl(2'(i % 4));
      case (sel)
        0:       f[i] = 8'((i + 1) * PIPE_SPACING);
        1:       f[i] = c + HALF_GAP;
        default: f[i] = c - HALF_GAP;
      endcase
    end
    return f;
  endfunction

  localparam logic [N_PIPE-1:0][7:0] INIT_POS = init_field(0);
  localparam logic [N_PIPE-1:0][7:0] INIT_MAX = init_field(1);
  localparam logic [N_PIPE-1:0][7:0] INIT_MIN = init_field(2);

  scene_e                  scene_r;
  logic signed [YW-1:0]    y, v;
  logic [KP_BUFLEN-1:0]    kpbuf;
  logic [7:0]              hold_cnt;
  logic [15:0]             score_r;
  logic [N_PIPE-1:0][7:0]  pos, max_b, min_b;

  logic                    space, flap, over, respawn_any;
  logic [7:0]              alt, centre;
  logic signed [YW-1:0]    v_dec, v_grav;
  logic [N_PIPE-1:0]       near, hit, at_zero, pass;
  logic [16:0]             score_sum;
  logic [15:0]             score_nxt;
  logic                    unused_ncol;

  assign unused_ncol = ^n_col;

  assign space = (inp == SPACE);
  assign alt   = y[FRAC_W+7:FRAC_W];
  assign flap  = |kpbuf;

  // Gravity with saturation at the terminal velocity
  assign v_dec  = v - GRAV_S;
  assign v_grav = (v_dec < VMIN_S) ? VMIN_S : v_dec;

  for (genvar i = 0; i < N_PIPE; i++) begin : g_pipe
    // |position - BIRD_COL| <= 2 without going signed
    assign near[i]    = ({1'b0, pos[i]} + 9'd2 >= 9'(BIRD_COL)) &&
                        ({1'b0, pos[i]} <= 9'(BIRD_COL + 2));
    assign hit[i]     = near[i] && ((alt >= max_b[i]) || (alt <= min_b[i]));
    assign at_zero[i] = (pos[i] == 8'd0);
    // A pipe at zero respawns instead of stepping, so it never scores
    assign pass[i]    = (pos[i] == 8'(BIRD_COL)) && !at_zero[i];

    assign pipes[PIPE_W*i + POS_OFF +: 8] = pos[i];
    assign pipes[PIPE_W*i + MAX_OFF +: 8] = max_b[i];
    assign pipes[PIPE_W*i + MIN_OFF +: 8] = min_b[i];
  end

  // Any death condition this cycle; alt+1 >= n_row is the ceiling test
  assign over = y[YW-1] ||
                (({1'b0, alt} + 9'd1) >= {1'b0, n_row}) ||
                (|hit);

  // Gap source only steps when a respawn actually commits
  assign respawn_any = (scene_r == SC_PLAYING) && !over && (|at_zero);

  flappy_gap_gen #(.GAP(GAP)) u_gap (
    .clk    (clk),
    .rst_n  (rst_n),
    .next   (respawn_any),
    .centre (centre)
  );

  // Score increment: one per pipe crossing the bird column, saturating
  always_comb begin
    score_sum = {1'b0, score_r};
    for (int i = 0; i < N_PIPE; i++)
      if (pass[i]) score_sum = score_sum + 17'd1;
    score_nxt = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  // Scene FSM plus all game state; restart reloads the reset values
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scene_r  <= SC_SPLASH;
      y        <= Y_INIT;
      v        <= '0;
      kpbuf    <= '0;
      hold_cnt <= 8'd0;
      score_r  <= 16'd0;
      pos      <= INIT_POS;
      max_b    <= INIT_MAX;
      min_b    <= INIT_MIN;
    end else begin
      case (scene_r)
        SC_SPLASH: begin
          if (space) begin
            scene_r <= SC_PLAYING;
            kpbuf   <= '0;
          end
        end
        SC_PLAYING: begin
          if (over) begin
            // Freeze everything as it stood when the collision was seen
            scene_r  <= SC_GAMEOVER;
            kpbuf    <= '0;
            hold_cnt <= 8'd0;
          end else begin
            kpbuf   <= {space, kpbuf[KP_BUFLEN-1:1]};
            v       <= flap ? FLAP_S : v_grav;
            y       <= y + v;
            score_r <= score_nxt;
            for (int i = 0; i < N_PIPE; i++) begin
              if (at_zero[i]) begin
                pos[i]   <= RESPAWN_POS;
                max_b[i] <= centre + HALF_GAP;
                min_b[i] <= centre - HALF_GAP;
              end else begin
                pos[i]   <= pos[i] - 8'd1;
              end
            end
          end
        end
        SC_GAMEOVER: begin
          if (space && (hold_cnt == HOLD_MAX)) begin
            scene_r  <= SC_SPLASH;
            y        <= Y_INIT;
            v        <= '0;
            kpbuf    <= '0;
            hold_cnt <= 8'd0;
            score_r  <= 16'd0;
            pos      <= INIT_POS;
            max_b    <= INIT_MAX;
            min_b    <= INIT_MIN;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: scene_r <= SC_SPLASH;
      endcase
    end
  end

  assign scene = scene_r;
  assign bird  = {alt, flap};
  assign score = score_r;

endmodule
